// File: rtl/adder_pkg.sv
// Purpose : shared widths and the adder result record used by the adder wrapper, the result buffer and benches.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package adder_pkg;

  localparam int ADD_W   = 8;
  localparam int TOTAL_W = 16;

  // One adder result: carry-out above the sum, so {cout, sum} reads as the full unsigned result.
  typedef struct packed {
    logic             cout;
    logic [ADD_W-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose : generic show-ahead FIFO; head entry is driven straight from storage at the read pointer.
// Latency : an entry written at edge N is visible on rd_dat after edge N; no empty bypass.
// Backpressure: wr_rdy = not full (independent of rd_rdy); rd_vld = not empty.
// Ports   : clk, rst (sync, active-high); wr_vld/wr_rdy/wr_dat write side; rd_vld/rd_rdy/rd_dat read side; level = stored entries.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign wr_rdy = (r_level != (AW+1)'(DEPTH));
  assign rd_vld = (r_level != '0);
  assign w_push = wr_vld & wr_rdy;
  assign w_pop  = rd_vld & rd_rdy;
  assign level  = r_level;

  // Zero while empty so a stale memory word never leaks onto the head outputs.
  assign rd_dat = rd_vld ? r_mem[r_rd_ptr] : '0;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (w_pop && !w_push) r_level <= r_level - (AW+1)'(1);
    end
  end

  // Storage is not reset; contents are only observable through rd_vld.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/adder_result_buffer.sv
// Purpose : buffers {sum, cout} adder results for the downstream writer and keeps running total / carry count / overflow stats.
// Latency : one cycle from accepted input to head output; stats update on the edge that accepts the input.
// Backpressure: in_ready drops only when the FIFO is full; it never looks at out_ready.
// Ports   : clk, rst; in_valid/in_ready/in_sum/in_cout; clear (stats only);
//           out_valid/out_ready/out_sum/out_cout; level, total, carry_cnt, total_ovf.
module adder_result_buffer #(
  parameter int WIDTH   = adder_pkg::ADD_W,
  parameter int DEPTH   = 4,
  parameter int TOTAL_W = adder_pkg::TOTAL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_sum,
  input  logic                     in_cout,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_cout,
  output logic [$clog2(DEPTH):0]   level,
  output logic [TOTAL_W-1:0]       total,
  output logic [7:0]               carry_cnt,
  output logic                     total_ovf
);

  import adder_pkg::*;

  logic [WIDTH:0]     w_wr_dat;
  logic [WIDTH:0]     w_rd_dat;
  logic               w_push;
  logic [TOTAL_W-1:0] w_base_total;
  logic [7:0]         w_base_cnt;
  logic               w_base_ovf;
  logic [TOTAL_W:0]   w_acc;
  logic [TOTAL_W-1:0] r_total;
  logic [7:0]         r_carry_cnt;
  logic               r_total_ovf;

  assign w_wr_dat = {in_cout, in_sum};

  sync_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (w_wr_dat),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (w_rd_dat),
    .level  (level)
  );

  assign out_cout = w_rd_dat[WIDTH];
  assign out_sum  = w_rd_dat[WIDTH-1:0];
  assign w_push   = in_valid & in_ready;

  // clear zeroes the starting point first, so a same-cycle push accumulates onto a fresh total.
  assign w_base_total = clear ? '0 : r_total;
  assign w_base_cnt   = clear ? '0 : r_carry_cnt;
  assign w_base_ovf   = clear ? 1'b0 : r_total_ovf;

  // One extra bit captures the wrap of the TOTAL_W-bit accumulator.
  assign w_acc = {1'b0, w_base_total} + {{(TOTAL_W - WIDTH){1'b0}}, in_cout, in_sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_total     <= '0;
      r_carry_cnt <= '0;
      r_total_ovf <= 1'b0;
    end else if (w_push) begin
      r_total     <= w_acc[TOTAL_W-1:0];
      r_total_ovf <= w_base_ovf | w_acc[TOTAL_W];
      if (in_cout && (w_base_cnt != 8'hFF)) r_carry_cnt <= w_base_cnt + 8'd1;
      else                                  r_carry_cnt <= w_base_cnt;
    end else if (clear) begin
      r_total     <= '0;
      r_carry_cnt <= '0;
      r_total_ovf <= 1'b0;
    end
  end

  assign total     = r_total;
  assign carry_cnt = r_carry_cnt;
  assign total_ovf = r_total_ovf;

endmodule

// File: tb/tb_adder_result_buffer.sv
// Bench for adder_result_buffer: queue/integer reference model, per-cycle compare on the falling edge,
// plus hand-computed literal checks at key points of the directed sequence.
module tb_adder_result_buffer;
  import adder_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_sum = '0;
  logic        in_cout = 1'b0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_sum;
  logic        out_cout;
  logic [2:0]  level;
  logic [15:0] total;
  logic [7:0]  carry_cnt;
  logic        total_ovf;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  add_result_t q[$];
  int          m_total = 0;
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;

  always #5 clk = ~clk;

  adder_result_buffer #(.WIDTH(8), .DEPTH(DEPTH), .TOTAL_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .level     (level),
    .total     (total),
    .carry_cnt (carry_cnt),
    .total_ovf (total_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, statistics as plain integer arithmetic.
  always @(posedge clk) begin
    bit push, pop;
    int t;
    add_result_t v;
    if (rst) begin
      q.delete();
      m_total = 0;
      m_cnt   = 0;
      m_ovf   = 1'b0;
    end else begin
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() != 0);
      if (clear) begin
        m_total = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
      end
      if (push) begin
        t = m_total + ((in_cout ? 256 : 0) + int'(in_sum));
        if (t > 65535) m_ovf = 1'b1;
        m_total = t % 65536;
        if (in_cout && m_cnt < 255) m_cnt++;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        v.cout = in_cout;
        v.sum  = in_sum;
        q.push_back(v);
      end
    end
  end

  // Compare every cycle once the DUT has been through reset.
  always @(negedge clk) begin
    if (chk_en) begin
      check("level",     32'(level),     32'(q.size()));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
      check("out_sum",   32'(out_sum),   (q.size() != 0) ? 32'(q[0].sum)  : 32'd0);
      check("out_cout",  32'(out_cout),  (q.size() != 0) ? 32'(q[0].cout) : 32'd0);
      check("total",     32'(total),     32'(m_total));
      check("carry_cnt", 32'(carry_cnt), 32'(m_cnt));
      check("total_ovf", 32'(total_ovf), 32'(m_ovf));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] s, input logic c);
    in_valid = v;
    in_sum   = s;
    in_cout  = c;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step(2);
    chk_en = 1'b1;
    check("rst_level",     32'(level),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_total",     32'(total),     32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    rst = 1'b0;
    step(1);

    // 1: two back-to-back pushes, no drain
    drive(1, 8'h7F, 0); step(1);
    drive(1, 8'h01, 1); step(1);
    drive(0, 8'h00, 0);
    check("t1_level",   32'(level),     32'd2);
    check("t1_out_sum", 32'(out_sum),   32'h7F);
    check("t1_cout",    32'(out_cout),  32'd0);
    check("t1_total",   32'(total),     32'h0180);
    check("t1_carry",   32'(carry_cnt), 32'd1);

    // 2: fill, hold a 5th value while full, then drain one
    drive(1, 8'h10, 0); step(1);
    drive(1, 8'h20, 0); step(1);
    check("t2_full_level", 32'(level),    32'd4);
    check("t2_full_rdy",   32'(in_ready), 32'd0);
    drive(1, 8'h33, 0); step(3);
    check("t2_held_level", 32'(level),    32'd4);
    check("t2_head_first", 32'(out_sum),  32'h7F);
    out_ready = 1'b1; step(1);
    out_ready = 1'b0;
    check("t2_pop_rdy",    32'(in_ready), 32'd1);
    check("t2_pop_head",   32'(out_sum),  32'h01);
    step(1);
    drive(0, 8'h00, 0);
    check("t2_accept_level", 32'(level), 32'd4);
    check("t2_total",        32'(total), 32'h01E3);

    // 3: steady push+pop at level 2, pointers wrap several times
    out_ready = 1'b1; step(2);
    out_ready = 1'b0;
    check("t3_start_level", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(8'h40 + i), i[0]);
      step(1);
      check("t3_level", 32'(level), 32'd2);
    end
    drive(0, 8'h00, 0);
    step(2);
    out_ready = 1'b0;
    check("t3_drained", 32'(level), 32'd0);

    // 4: total reaches 0xFF00, then wraps
    clear = 1'b1; step(1); clear = 1'b0;
    check("t4_cleared", 32'(total), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 127; i++) begin
      drive(1, 8'hFF, 1); step(1);
    end
    drive(1, 8'h7F, 1); step(1);
    drive(0, 8'h00, 0);
    check("t4_preload", 32'(total),     32'hFF00);
    check("t4_no_ovf",  32'(total_ovf), 32'd0);
    drive(1, 8'hFF, 1); step(1);
    drive(0, 8'h00, 0);
    check("t4_wrap_total", 32'(total),     32'h00FF);
    check("t4_wrap_ovf",   32'(total_ovf), 32'd1);
    drive(1, 8'h02, 0); step(1);
    drive(1, 8'h03, 0); step(1);
    drive(0, 8'h00, 0);
    check("t4_ovf_sticky", 32'(total_ovf), 32'd1);

    // 5: carry count saturates, then clear with simultaneous push
    for (int i = 0; i < 256; i++) begin
      drive(1, 8'h00, 1); step(1);
    end
    drive(0, 8'h00, 0);
    check("t5_sat", 32'(carry_cnt), 32'd255);
    clear = 1'b1;
    drive(1, 8'h05, 1); step(1);
    clear = 1'b0;
    drive(0, 8'h00, 0);
    check("t5_clr_total", 32'(total),     32'h0105);
    check("t5_clr_carry", 32'(carry_cnt), 32'd1);
    check("t5_clr_ovf",   32'(total_ovf), 32'd0);
    step(2);
    out_ready = 1'b0;

    // 6: reset mid-stream with in_valid high
    drive(1, 8'hA1, 0); step(1);
    drive(1, 8'hA2, 1); step(1);
    drive(1, 8'hA3, 0); step(1);
    check("t6_level3", 32'(level), 32'd3);
    rst = 1'b1;
    drive(1, 8'hA4, 1); step(1);
    rst = 1'b0;
    drive(0, 8'h00, 0);
    check("t6_rst_level", 32'(level),     32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_total", 32'(total),     32'd0);
    step(1);
    check("t6_not_stored", 32'(level), 32'd0);

    step(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
